// File: rtl/burst_ram_arbiter.sv
// Two-port round-robin front end that lets two caches share one BurstRAM.
// Define ARB_STATS_EN to add per-port grant and conflict counters.
`timescale 1ns/1ps
module burst_ram_arbiter #(
    parameter int DEPTH_BITWIDTH = 10,
    parameter int BURST_COUNT    = 4,
    parameter int DATA_WIDTH     = 64
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      p0_cmd,
    input  logic                      p0_cmd_en,
    input  logic [DEPTH_BITWIDTH-1:0] p0_addr,
    input  logic [DATA_WIDTH-1:0]     p0_wr_data,
    input  logic [7:0]                p0_data_mask,
    output logic [DATA_WIDTH-1:0]     p0_rd_data,
    output logic                      p0_rd_data_valid,
    output logic                      p0_busy,
    input  logic                      p1_cmd,
    input  logic                      p1_cmd_en,
    input  logic [DEPTH_BITWIDTH-1:0] p1_addr,
    input  logic [DATA_WIDTH-1:0]     p1_wr_data,
    input  logic [7:0]                p1_data_mask,
    output logic [DATA_WIDTH-1:0]     p1_rd_data,
    output logic                      p1_rd_data_valid,
    output logic                      p1_busy,
    output logic                      br_cmd,
    output logic                      br_cmd_en,
    output logic [DEPTH_BITWIDTH-1:0] br_addr,
    output logic [DATA_WIDTH-1:0]     br_wr_data,
    output logic [7:0]                br_data_mask,
    input  logic [DATA_WIDTH-1:0]     br_rd_data,
    input  logic                      br_rd_data_valid,
    input  logic                      br_busy
`ifdef ARB_STATS_EN
    ,
    output logic [31:0]               stat_grants0,
    output logic [31:0]               stat_grants1,
    output logic [31:0]               stat_conflicts
`endif
);

    localparam int BW = $clog2(BURST_COUNT);
    localparam logic [BW-1:0] ONE       = BW'(1);
    localparam logic [BW-1:0] LAST_BEAT = BW'(BURST_COUNT - 1);

    typedef logic [DATA_WIDTH-1:0]     beat_t;
    typedef logic [DEPTH_BITWIDTH-1:0] addr_t;
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WBEATS, S_RWAIT} state_t;

    logic  cmd_in    [2];
    logic  cmd_en_in [2];
    addr_t addr_in   [2];
    beat_t wr_in     [2];
    logic [7:0] mask_in [2];

    assign cmd_in[0]    = p0_cmd;
    assign cmd_in[1]    = p1_cmd;
    assign cmd_en_in[0] = p0_cmd_en;
    assign cmd_en_in[1] = p1_cmd_en;
    assign addr_in[0]   = p0_addr;
    assign addr_in[1]   = p1_addr;
    assign wr_in[0]     = p0_wr_data;
    assign wr_in[1]     = p1_wr_data;
    assign mask_in[0]   = p0_data_mask;
    assign mask_in[1]   = p1_data_mask;

    // Per-port capture state: command fields plus the write-beat buffer.
    logic          busy_q  [2], busy_d  [2];
    logic          pend_q  [2], pend_d  [2];
    logic          pcmd_q  [2], pcmd_d  [2];
    addr_t         paddr_q [2], paddr_d [2];
    logic [7:0]    pmask_q [2], pmask_d [2];
    beat_t         wbuf_q  [2][BURST_COUNT];
    beat_t         wbuf_d  [2][BURST_COUNT];
    logic          wcap_q  [2], wcap_d  [2];
    logic [BW-1:0] wcnt_q  [2], wcnt_d  [2];
    beat_t         hold_q  [2], hold_d  [2];

    state_t        state_q, state_d;
    logic          owner_q, owner_d;
    logic          last_grant_q, last_grant_d;
    logic [BW-1:0] beat_q, beat_d;
    logic          br_cmd_q, br_cmd_d;
    addr_t         br_addr_q, br_addr_d;
    logic          br_cmd_en_q, br_cmd_en_d;

    logic          capture  [2];
    logic          req      [2];
    logic          eff_cmd  [2];
    addr_t         eff_addr [2];
    logic          gnt;

    always_comb begin
        busy_d       = busy_q;
        pend_d       = pend_q;
        pcmd_d       = pcmd_q;
        paddr_d      = paddr_q;
        pmask_d      = pmask_q;
        wbuf_d       = wbuf_q;
        wcap_d       = wcap_q;
        wcnt_d       = wcnt_q;
        hold_d       = hold_q;
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        beat_d       = beat_q;
        br_cmd_d     = br_cmd_q;
        br_addr_d    = br_addr_q;
        br_cmd_en_d  = 1'b0;
        gnt          = 1'b0;

        for (int i = 0; i < 2; i++) begin
            capture[i]  = cmd_en_in[i] && !busy_q[i];
            req[i]      = pend_q[i] || capture[i];
            eff_cmd[i]  = capture[i] ? cmd_in[i] : pcmd_q[i];
            eff_addr[i] = capture[i] ? addr_in[i] : paddr_q[i];
            if (capture[i]) begin
                busy_d[i]     = 1'b1;
                pend_d[i]     = 1'b1;
                pcmd_d[i]     = cmd_in[i];
                paddr_d[i]    = addr_in[i];
                pmask_d[i]    = mask_in[i];
                wbuf_d[i][0]  = wr_in[i];
                wcap_d[i]     = cmd_in[i];
                wcnt_d[i]     = ONE;
            end else if (wcap_q[i]) begin
                wbuf_d[i][wcnt_q[i]] = wr_in[i];
                wcnt_d[i]            = wcnt_q[i] + ONE;
                if (wcnt_q[i] == LAST_BEAT) begin
                    wcap_d[i] = 1'b0;
                end
            end
        end

        // A command captured on this edge may be granted on the same edge,
        // which is why the grant looks at the incoming fields directly.
        case (state_q)
            S_IDLE: begin
                if (!br_busy && (req[0] || req[1])) begin
                    gnt          = (req[0] && req[1]) ? !last_grant_q : req[1];
                    owner_d      = gnt;
                    last_grant_d = gnt;
                    pend_d[gnt]  = 1'b0;
                    br_cmd_en_d  = 1'b1;
                    br_cmd_d     = eff_cmd[gnt];
                    br_addr_d    = eff_addr[gnt];
                    beat_d       = '0;
                    state_d      = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (pcmd_q[owner_q]) begin
                    beat_d  = ONE;
                    state_d = S_WBEATS;
                end else begin
                    beat_d  = '0;
                    state_d = S_RWAIT;
                end
            end
            S_WBEATS: begin
                beat_d = beat_q + ONE;
                if (beat_q == LAST_BEAT) begin
                    busy_d[owner_q] = 1'b0;
                    state_d         = S_IDLE;
                end
            end
            S_RWAIT: begin
                if (br_rd_data_valid) begin
                    hold_d[owner_q] = br_rd_data;
                    beat_d          = beat_q + ONE;
                    if (beat_q == LAST_BEAT) begin
                        busy_d[owner_q] = 1'b0;
                        state_d         = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                busy_q[i]  <= 1'b0;
                pend_q[i]  <= 1'b0;
                pcmd_q[i]  <= 1'b0;
                paddr_q[i] <= '0;
                pmask_q[i] <= '0;
                wcap_q[i]  <= 1'b0;
                wcnt_q[i]  <= '0;
                hold_q[i]  <= '0;
                for (int k = 0; k < BURST_COUNT; k++) begin
                    wbuf_q[i][k] <= '0;
                end
            end
            state_q      <= S_IDLE;
            owner_q      <= 1'b0;
            last_grant_q <= 1'b1;
            beat_q       <= '0;
            br_cmd_q     <= 1'b0;
            br_addr_q    <= '0;
            br_cmd_en_q  <= 1'b0;
        end else begin
            busy_q       <= busy_d;
            pend_q       <= pend_d;
            pcmd_q       <= pcmd_d;
            paddr_q      <= paddr_d;
            pmask_q      <= pmask_d;
            wcap_q       <= wcap_d;
            wcnt_q       <= wcnt_d;
            hold_q       <= hold_d;
            wbuf_q       <= wbuf_d;
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            beat_q       <= beat_d;
            br_cmd_q     <= br_cmd_d;
            br_addr_q    <= br_addr_d;
            br_cmd_en_q  <= br_cmd_en_d;
        end
    end

    // Write beats are read from the buffer one cycle after they are stored.
    logic drive_w;
    logic rwait0, rwait1;

    assign drive_w      = (state_q == S_ISSUE) || (state_q == S_WBEATS);
    assign br_cmd_en    = br_cmd_en_q;
    assign br_cmd       = br_cmd_q;
    assign br_addr      = br_addr_q;
    assign br_wr_data   = drive_w ? wbuf_q[owner_q][beat_q] : '0;
    assign br_data_mask = drive_w ? pmask_q[owner_q] : '0;

    assign rwait0 = (state_q == S_RWAIT) && (owner_q == 1'b0);
    assign rwait1 = (state_q == S_RWAIT) && (owner_q == 1'b1);

    assign p0_rd_data       = rwait0 ? br_rd_data : hold_q[0];
    assign p1_rd_data       = rwait1 ? br_rd_data : hold_q[1];
    assign p0_rd_data_valid = rwait0 && br_rd_data_valid;
    assign p1_rd_data_valid = rwait1 && br_rd_data_valid;
    assign p0_busy          = busy_q[0];
    assign p1_busy          = busy_q[1];

`ifdef ARB_STATS_EN
    logic [31:0] grants_q [2], grants_d [2];
    logic [31:0] conflicts_q, conflicts_d;

    always_comb begin
        grants_d    = grants_q;
        conflicts_d = conflicts_q;
        if (state_q == S_ISSUE) begin
            grants_d[owner_q] = grants_q[owner_q] + 32'd1;
        end
        if ((state_q == S_IDLE) && !br_busy && req[0] && req[1]) begin
            conflicts_d = conflicts_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grants_q[0] <= '0;
            grants_q[1] <= '0;
            conflicts_q <= '0;
        end else begin
            grants_q    <= grants_d;
            conflicts_q <= conflicts_d;
        end
    end

    assign stat_grants0   = grants_q[0];
    assign stat_grants1   = grants_q[1];
    assign stat_conflicts = conflicts_q;
`endif

endmodule

// File: tb/tb_burst_ram_arbiter.sv
// Scoreboard bench for burst_ram_arbiter with a small behavioural BurstRAM.
`timescale 1ns/1ps
module tb_burst_ram_arbiter;
    localparam int AW = 10;
    localparam int BC = 4;
    localparam int DW = 64;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          p0_cmd = 1'b0, p0_cmd_en = 1'b0;
    logic [AW-1:0] p0_addr = '0;
    logic [DW-1:0] p0_wr_data = '0;
    logic [7:0]    p0_data_mask = '0;
    logic [DW-1:0] p0_rd_data;
    logic          p0_rd_data_valid, p0_busy;
    logic          p1_cmd = 1'b0, p1_cmd_en = 1'b0;
    logic [AW-1:0] p1_addr = '0;
    logic [DW-1:0] p1_wr_data = '0;
    logic [7:0]    p1_data_mask = '0;
    logic [DW-1:0] p1_rd_data;
    logic          p1_rd_data_valid, p1_busy;
    logic          br_cmd, br_cmd_en;
    logic [AW-1:0] br_addr;
    logic [DW-1:0] br_wr_data;
    logic [7:0]    br_data_mask;
    logic [DW-1:0] br_rd_data = '0;
    logic          br_rd_data_valid = 1'b0;
    logic          br_busy;
    logic          force_busy = 1'b0;
`ifdef ARB_STATS_EN
    logic [31:0]   stat_grants0, stat_grants1, stat_conflicts;
`endif

    assign br_busy = force_busy;

    burst_ram_arbiter #(.DEPTH_BITWIDTH(AW), .BURST_COUNT(BC), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst(rst),
        .p0_cmd(p0_cmd), .p0_cmd_en(p0_cmd_en), .p0_addr(p0_addr), .p0_wr_data(p0_wr_data),
        .p0_data_mask(p0_data_mask), .p0_rd_data(p0_rd_data), .p0_rd_data_valid(p0_rd_data_valid),
        .p0_busy(p0_busy),
        .p1_cmd(p1_cmd), .p1_cmd_en(p1_cmd_en), .p1_addr(p1_addr), .p1_wr_data(p1_wr_data),
        .p1_data_mask(p1_data_mask), .p1_rd_data(p1_rd_data), .p1_rd_data_valid(p1_rd_data_valid),
        .p1_busy(p1_busy),
        .br_cmd(br_cmd), .br_cmd_en(br_cmd_en), .br_addr(br_addr), .br_wr_data(br_wr_data),
        .br_data_mask(br_data_mask), .br_rd_data(br_rd_data), .br_rd_data_valid(br_rd_data_valid),
        .br_busy(br_busy)
`ifdef ARB_STATS_EN
        , .stat_grants0(stat_grants0), .stat_grants1(stat_grants1), .stat_conflicts(stat_conflicts)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        logic                 cmd;
        logic [AW-1:0]        addr;
        logic [7:0]           mask;
        logic [BC-1:0][DW-1:0] d;
        int                   cyc;
    } cmd_t;

    cmd_t          cmd_q[$];
    logic [DW-1:0] rd_q0[$];
    logic [DW-1:0] rd_q1[$];
    int            rd_seen0 = 0;
    int            rd_seen1 = 0;

    // Command-side monitor: every br_cmd_en must match the next expected grant.
    cmd_t cur;
    int   wchk = 0;
    always @(negedge clk) begin
        if (wchk > 0 && wchk < BC) begin
            check("br_wr_beat", br_wr_data, cur.d[wchk]);
            wchk++;
        end
        if (br_cmd_en) begin
            if (cmd_q.size() == 0) begin
                check("br_cmd_en_unexpected", 64'd1, 64'd0);
            end else begin
                cur = cmd_q.pop_front();
                check("br_cmd", {63'd0, br_cmd}, {63'd0, cur.cmd});
                check("br_addr", {54'd0, br_addr}, {54'd0, cur.addr});
                if (cur.cyc >= 0) check("issue_cycle", 64'(cyc), 64'(cur.cyc));
                if (cur.cmd) begin
                    check("br_wr_beat0", br_wr_data, cur.d[0]);
                    check("br_data_mask", {56'd0, br_data_mask}, {56'd0, cur.mask});
                    wchk = 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (p0_rd_data_valid) begin
            if (rd_q0.size() == 0) check("p0_rd_valid_unexpected", 64'd1, 64'd0);
            else check("p0_rd_data", p0_rd_data, rd_q0.pop_front());
            rd_seen0++;
        end
    end

    always @(negedge clk) begin
        if (p1_rd_data_valid) begin
            if (rd_q1.size() == 0) check("p1_rd_valid_unexpected", 64'd1, 64'd0);
            else check("p1_rd_data", p1_rd_data, rd_q1.pop_front());
            rd_seen1++;
        end
    end

    // Behavioural BurstRAM: read beats start two cycles after the command.
    logic [DW-1:0] mem [0:(1<<AW)-1];
    int            rd_left = 0, rd_k = 0, rd_delay = 0;
    int            wr_on = 0, wr_k = 0;
    logic [AW-1:0] rd_addr = '0, wr_addr = '0;

    always @(negedge clk) begin
        if (br_cmd_en && !br_cmd) begin
            rd_addr  = br_addr;
            rd_delay = 1;
            rd_left  = BC;
            rd_k     = 0;
        end
        if (br_cmd_en && br_cmd) begin
            wr_addr = br_addr;
            wr_k    = 0;
            wr_on   = 1;
        end
        if (wr_on != 0) begin
            mem[wr_addr + AW'(wr_k)] = br_wr_data;
            wr_k++;
            if (wr_k == BC) wr_on = 0;
        end
    end

    always @(posedge clk) begin
        #1;
        if (rd_left > 0 && rd_delay == 0) begin
            br_rd_data       = mem[rd_addr + AW'(rd_k)];
            br_rd_data_valid = 1'b1;
            rd_k++;
            rd_left--;
        end else begin
            br_rd_data_valid = 1'b0;
            if (rd_delay > 0) rd_delay--;
        end
    end

    task automatic set_port(input int p, input logic en, input logic c, input logic [AW-1:0] a,
                            input logic [7:0] m, input logic [DW-1:0] wd);
        if (p == 0) begin
            p0_cmd_en = en; p0_cmd = c; p0_addr = a; p0_data_mask = m; p0_wr_data = wd;
        end else begin
            p1_cmd_en = en; p1_cmd = c; p1_addr = a; p1_data_mask = m; p1_wr_data = wd;
        end
    endtask

    task automatic push_cmd(input logic c, input logic [AW-1:0] a, input logic [7:0] m,
                            input logic [BC-1:0][DW-1:0] d, input int ecyc);
        cmd_t e;
        e.cmd = c; e.addr = a; e.mask = m; e.d = d; e.cyc = ecyc;
        cmd_q.push_back(e);
    endtask

    task automatic issue(input int p, input logic c, input logic [AW-1:0] a, input logic [7:0] m,
                         input logic [BC-1:0][DW-1:0] d, input int lat, input bit chk);
        int last;
        last = c ? (chk ? BC + 1 : BC) : 1;
        for (int k = 0; k <= last; k++) begin
            @(posedge clk); #1;
            if (k == 0) begin
                push_cmd(c, a, m, d, (lat >= 0) ? cyc + lat : -1);
                set_port(p, 1'b1, c, a, m, d[0]);
            end else if (c && k < BC) begin
                set_port(p, 1'b0, c, a, m, d[k]);
            end else begin
                set_port(p, 1'b0, c, a, m, '0);
            end
            if (chk) begin
                @(negedge clk);
                check(p == 0 ? "p0_busy" : "p1_busy", {63'd0, (p == 0) ? p0_busy : p1_busy},
                      {63'd0, (k >= 1 && k <= BC)});
            end
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while ((p0_busy || p1_busy) && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) check("busy_timeout", 64'd1, 64'd0);
        repeat (2) @(posedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_br_cmd_en"}, {63'd0, br_cmd_en}, 64'd0);
        check({tag, "_br_cmd"}, {63'd0, br_cmd}, 64'd0);
        check({tag, "_br_addr"}, {54'd0, br_addr}, 64'd0);
        check({tag, "_br_wr_data"}, br_wr_data, 64'd0);
        check({tag, "_br_data_mask"}, {56'd0, br_data_mask}, 64'd0);
        check({tag, "_busy"}, {62'd0, p1_busy, p0_busy}, 64'd0);
        check({tag, "_rd_valid"}, {62'd0, p1_rd_data_valid, p0_rd_data_valid}, 64'd0);
        check({tag, "_p0_rd_data"}, p0_rd_data, 64'd0);
        check({tag, "_p1_rd_data"}, p1_rd_data, 64'd0);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    localparam logic [BC-1:0][DW-1:0] D_A = {64'd4, 64'd3, 64'd2, 64'd1};
    localparam logic [BC-1:0][DW-1:0] D_B = {64'd8, 64'd7, 64'd6, 64'd5};

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int n;
        int b;

        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst = 1'b0;

        // Port 0 write 1..4 to 0x010 on an idle RAM; issue exactly one cycle later.
        issue(0, 1'b1, 10'h010, 8'hA5, D_A, 1, 1'b1);
        wait_idle();
        // Port 1 write 5..8 to 0x014.
        issue(1, 1'b1, 10'h014, 8'h0F, D_B, 1, 1'b1);
        wait_idle();

        // Port 1 reads back port 0's burst; port 0 must see nothing.
        for (int k = 0; k < BC; k++) rd_q1.push_back(D_A[k]);
        issue(1, 1'b0, 10'h010, 8'h00, '0, 1, 1'b0);
        wait_idle();

        // Simultaneous reads after reset: grant order 0,1,0,1.
        do_reset();
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < BC; k++) begin
                rd_q0.push_back(D_A[k]);
                rd_q1.push_back(D_B[k]);
            end
            @(posedge clk); #1;
            push_cmd(1'b0, 10'h010, 8'h00, '0, cyc + 1);
            push_cmd(1'b0, 10'h014, 8'h00, '0, -1);
            set_port(0, 1'b1, 1'b0, 10'h010, 8'h00, '0);
            set_port(1, 1'b1, 1'b0, 10'h014, 8'h00, '0);
            @(posedge clk); #1;
            set_port(0, 1'b0, 1'b0, 10'h010, 8'h00, '0);
            set_port(1, 1'b0, 1'b0, 10'h014, 8'h00, '0);
            wait_idle();
        end
`ifdef ARB_STATS_EN
        check("stat_grants0", {32'd0, stat_grants0}, 64'd2);
        check("stat_grants1", {32'd0, stat_grants1}, 64'd2);
        check("stat_conflicts", {32'd0, stat_conflicts}, 64'd2);
`endif

        // RAM busy for 20 cycles with port 0 pending; issue one cycle after it drops.
        @(posedge clk); #1;
        force_busy = 1'b1;
        b = cyc;
        for (int k = 0; k < BC; k++) rd_q0.push_back(D_B[k]);
        @(posedge clk); #1;
        push_cmd(1'b0, 10'h014, 8'h00, '0, b + 21);
        set_port(0, 1'b1, 1'b0, 10'h014, 8'h00, '0);
        @(posedge clk); #1;
        set_port(0, 1'b0, 1'b0, 10'h014, 8'h00, '0);
        repeat (18) @(posedge clk);
        #1;
        force_busy = 1'b0;
        wait_idle();

        // Reset pulse mid-read after two beats; the rest must be dropped.
        for (int k = 0; k < BC; k++) rd_q0.push_back(D_A[k]);
        base = rd_seen0;
        issue(0, 1'b0, 10'h010, 8'h00, '0, -1, 1'b0);
        n = 0;
        while (rd_seen0 < base + 2 && n < 100) begin
            @(negedge clk); #1;
            n++;
        end
        if (n >= 100) check("rd_wait_timeout", 64'd1, 64'd0);
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        check_reset_outputs("midreset");
        rd_q0.delete();
        #1;
        rst = 1'b0;
        repeat (6) @(posedge clk);

        // Port 0 read after the reset completes normally.
        for (int k = 0; k < BC; k++) rd_q0.push_back(D_A[k]);
        base = rd_seen0;
        issue(0, 1'b0, 10'h010, 8'h00, '0, 1, 1'b0);
        wait_idle();
        check("final_read_beats", 64'(rd_seen0 - base), 64'(BC));

        n = 0;
        while ((cmd_q.size() != 0 || rd_q0.size() != 0 || rd_q1.size() != 0) && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("cmd_q_left", 64'(cmd_q.size()), 64'd0);
        check("rd_q0_left", 64'(rd_q0.size()), 64'd0);
        check("rd_q1_left", 64'(rd_q1.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
